// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - retirement writeback trace FIFO with sequence tags and shadow register file
module wb_trace_buffer #(
    parameter int DEPTH   = 16,
    parameter int DROP_X0 = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_e,
    input  logic [4:0]               wb_a,
    input  logic [31:0]              wb_d,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_addr,
    output logic [31:0]              out_data,
    output logic [15:0]              out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              overflow_cnt,
    input  logic [4:0]               shadow_rd_a,
    output logic [31:0]              shadow_rd_d
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      seq_q, seq_d;
    logic [15:0]      overflow_q, overflow_d;

    logic [4:0]       addr_mem_q [DEPTH];
    logic [4:0]       addr_mem_d [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];
    logic [31:0]      data_mem_d [DEPTH];
    logic [15:0]      seq_mem_q  [DEPTH];
    logic [15:0]      seq_mem_d  [DEPTH];
    logic [31:0]      shadow_q   [32];
    logic [31:0]      shadow_d   [32];

    logic qual;
    logic pop;
    logic push;

    always_comb begin
        qual = wb_e && !((DROP_X0 != 0) && (wb_a == 5'd0));
        pop  = (count_q != '0) && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push = qual && !flush && ((count_q != CNT_W'(DEPTH)) || pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        seq_mem_d  = seq_mem_q;
        shadow_d   = shadow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                addr_mem_d[wr_ptr_q] = wb_a;
                data_mem_d[wr_ptr_q] = wb_d;
                seq_mem_d[wr_ptr_q]  = seq_q;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (qual && !push && (overflow_q != 16'hFFFF)) begin
                overflow_d = overflow_q + 16'd1;
            end
        end

        // Sequence and shadow state track every committed writeback, even dropped ones.
        if (qual) begin
            seq_d = seq_q + 16'd1;
            if (wb_a != 5'd0) begin
                shadow_d[wb_a] = wb_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= '0;
            for (int i = 0; i < 32; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            shadow_q   <= shadow_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
        seq_mem_q  <= seq_mem_d;
    end

    assign out_valid    = (count_q != '0);
    assign out_addr     = addr_mem_q[rd_ptr_q];
    assign out_data     = data_mem_q[rd_ptr_q];
    assign out_seq      = seq_mem_q[rd_ptr_q];
    assign count        = count_q;
    assign overflow_cnt = overflow_q;
    assign shadow_rd_d  = (shadow_rd_a == 5'd0) ? 32'd0 : shadow_q[shadow_rd_a];

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - self-checking bench for wb_trace_buffer against a queue model
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_e = 1'b0;
    logic [4:0]  wb_a = '0;
    logic [31:0] wb_d = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic [15:0] out_seq;
    logic [4:0]  count;
    logic [15:0] overflow_cnt;
    logic [4:0]  shadow_rd_a = '0;
    logic [31:0] shadow_rd_d;

    wb_trace_buffer #(.DEPTH(DEPTH), .DROP_X0(1)) dut (
        .clk(clk), .reset(rst_n), .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_seq(out_seq),
        .count(count), .overflow_cnt(overflow_cnt),
        .shadow_rd_a(shadow_rd_a), .shadow_rd_d(shadow_rd_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          seq;
    } entry_t;

    entry_t      m_q[$];
    int          m_seq = 0;
    int          m_ovf = 0;
    logic [31:0] m_shadow [32];
    bit          checking = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial for (int i = 0; i < 32; i++) m_shadow[i] = '0;

    // Reference model: pop first, then the writeback takes the slot if one is free.
    always @(posedge clk) begin
        bit     q_ok;
        entry_t e;
        if (!rst_n) begin
            m_q.delete();
            m_seq = 0;
            m_ovf = 0;
            for (int i = 0; i < 32; i++) m_shadow[i] = '0;
            checking = 1;
        end else begin
            q_ok = wb_e && (wb_a != 5'd0);
            if (flush) begin
                m_q.delete();
            end else begin
                if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
                if (q_ok) begin
                    if (m_q.size() < DEPTH) begin
                        e.addr = wb_a; e.data = wb_d; e.seq = m_seq;
                        m_q.push_back(e);
                    end else if (m_ovf != 16'hFFFF) begin
                        m_ovf++;
                    end
                end
            end
            if (q_ok) begin
                m_seq = (m_seq + 1) % 65536;
                m_shadow[wb_a] = wb_d;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("count", 64'(count), 64'(m_q.size()));
            chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
            chk("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
            chk("shadow_rd_d", 64'(shadow_rd_d), 64'(m_shadow[shadow_rd_a]));
            if (m_q.size() != 0) begin
                chk("out_addr", 64'(out_addr), 64'(m_q[0].addr));
                chk("out_data", 64'(out_data), 64'(m_q[0].data));
                chk("out_seq", 64'(out_seq), 64'(m_q[0].seq));
            end
        end
    end

    task automatic step(input logic e, input logic [4:0] a, input logic [31:0] d,
                        input logic rdy, input logic fl);
        wb_e = e; wb_a = a; wb_d = d; out_ready = rdy; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 5'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();
        do_reset();
        chk("lit_reset_count", 64'(count), 64'd0);
        chk("lit_reset_valid", 64'(out_valid), 64'd0);

        step(1, 5'd1, 32'h11, 0, 0);
        step(1, 5'd2, 32'h22, 0, 0);
        step(1, 5'd3, 32'h33, 0, 0);
        chk("lit_t1_count", 64'(count), 64'd3);
        chk("lit_t1_addr", 64'(out_addr), 64'd1);
        chk("lit_t1_data", 64'(out_data), 64'h11);
        chk("lit_t1_seq", 64'(out_seq), 64'd0);
        idle(1);
        chk("lit_t1_seq1", 64'(out_seq), 64'd1);
        idle(1);
        chk("lit_t1_seq2", 64'(out_seq), 64'd2);
        idle(1);
        chk("lit_t1_empty", 64'(count), 64'd0);

        do_reset();
        for (int i = 0; i < 20; i++) step(1, 5'd5, 32'(i), 0, 0);
        chk("lit_t2_count", 64'(count), 64'd16);
        chk("lit_t2_ovf", 64'(overflow_cnt), 64'd4);
        chk("lit_t2_head", 64'(out_seq), 64'd0);
        for (int i = 0; i < 16; i++) idle(1);
        step(1, 5'd5, 32'h500, 0, 0);
        chk("lit_t2_seq20", 64'(out_seq), 64'd20);

        for (int i = 0; i < 15; i++) step(1, 5'd6, 32'h600 + 32'(i), 0, 0);
        chk("lit_t3_full", 64'(count), 64'd16);
        step(1, 5'd8, 32'hBEEF, 1, 0);
        chk("lit_t3_count", 64'(count), 64'd16);
        chk("lit_t3_ovf", 64'(overflow_cnt), 64'd4);
        for (int i = 0; i < 15; i++) idle(1);
        chk("lit_t3_tail_data", 64'(out_data), 64'hBEEF);
        chk("lit_t3_tail_seq", 64'(out_seq), 64'd36);
        idle(1);

        shadow_rd_a = 5'd0;
        step(1, 5'd0, 32'hDEAD, 0, 0);
        chk("lit_t4_x0_count", 64'(count), 64'd0);
        chk("lit_t4_x0_rd", 64'(shadow_rd_d), 64'd0);
        shadow_rd_a = 5'd7;
        step(1, 5'd7, 32'hCAFEBABE, 0, 0);
        chk("lit_t4_x7_rd", 64'(shadow_rd_d), 64'hCAFEBABE);
        chk("lit_t4_seq", 64'(out_seq), 64'd37);
        idle(1);

        for (int i = 0; i < 5; i++) step(1, 5'(10 + i), 32'h1000 + 32'(i), 0, 0);
        shadow_rd_a = 5'd9;
        step(1, 5'd9, 32'h99, 0, 1);
        chk("lit_t5_count", 64'(count), 64'd0);
        chk("lit_t5_valid", 64'(out_valid), 64'd0);
        chk("lit_t5_ovf", 64'(overflow_cnt), 64'd4);
        chk("lit_t5_shadow9", 64'(shadow_rd_d), 64'h99);
        step(1, 5'd4, 32'h44, 0, 0);
        chk("lit_t5_seq", 64'(out_seq), 64'd44);

        for (int i = 0; i < 3; i++) step(1, 5'(1 + i), 32'h2000 + 32'(i), 0, 0);
        idle(1);
        do_reset();
        chk("lit_t6_count", 64'(count), 64'd0);
        chk("lit_t6_ovf", 64'(overflow_cnt), 64'd0);
        for (int r = 1; r < 32; r++) begin
            shadow_rd_a = 5'(r);
            idle(0);
            chk("lit_t6_shadow", 64'(shadow_rd_d), 64'd0);
        end
        step(1, 5'd1, 32'h77, 0, 0);
        chk("lit_t6_seq0", 64'(out_seq), 64'd0);

        for (int i = 0; i < 300; i++) begin
            shadow_rd_a = 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
